// File: rtl/seg7_scan_ctrl.sv
// Multiplexed N-digit common-anode 7-seg scanner: shadow/display registers, dead-time gaps, blanking.
// All outputs registered and updated on the same edge as the scan state; no input-to-output paths.

module segment_7s (
    input  logic [3:0] bin_in,
    output logic [6:0] seg
);
    // seg = {g,f,e,d,c,b,a}, active-low
    always_comb begin
        seg = 7'h7F;
        case (bin_in)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end
endmodule

module seg7_scan_ctrl #(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    output logic [N_DIGITS-1:0]     an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);
    localparam int MAX_CYC = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    typedef enum logic {ST_DEAD = 1'b0, ST_ON = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
    logic [N_DIGITS-1:0]     shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
    logic                    pending_q, pending_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    commit;
    logic [3:0]              dec_in;
    logic [6:0]              dec_seg;
    logic                    lz_blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_DEAD;
            cnt_q        <= '0;
            idx_q        <= IDX_LAST;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        commit  = 1'b0;
        if (!en) begin
            state_d = ST_DEAD;
            cnt_d   = '0;
            idx_d   = IDX_LAST;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = ST_DEAD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        commit  = (idx_d == '0);
                    end
                end
            endcase
        end

        // The commit reads the old shadow, so a load on the commit edge waits a frame.
        shadow_val_d = load ? value_in : shadow_val_q;
        shadow_dp_d  = load ? dp_in    : shadow_dp_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        pending_d    = pending_q;
        if (commit && pending_q) begin
            disp_val_d = shadow_val_q;
            disp_dp_d  = shadow_dp_q;
            pending_d  = 1'b0;
        end
        if (load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        dec_in   = 4'h0;
        lz_blank = 1'b1;
        for (int j = 0; j < N_DIGITS; j++) begin
            if (IDX_W'(j) == idx_d) begin
                dec_in = disp_val_d[j*4 +: 4];
            end
            if (j >= int'(idx_d) && disp_val_d[j*4 +: 4] != 4'h0) begin
                lz_blank = 1'b0;
            end
        end
        lz_blank = lz_blank && blank_lz && (idx_d != '0);
    end

    segment_7s u_dec (
        .bin_in (dec_in),
        .seg    (dec_seg)
    );

    always_comb begin
        an_d         = '1;
        seg_d        = 7'h7F;
        dp_d         = 1'b1;
        frame_tick_d = commit;
        if (state_d == ST_ON && !lz_blank) begin
            seg_d = dec_seg;
            for (int j = 0; j < N_DIGITS; j++) begin
                if (IDX_W'(j) == idx_d) begin
                    an_d[j] = 1'b0;
                    dp_d    = ~disp_dp_d[j];
                end
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a 4-digit, 4-cycle-on, 1-cycle-dead scan (20-cycle frame).
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, en, load, blank_lz;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_tick;

    int total = 0;
    int bad   = 0;

    seg7_scan_ctrl #(
        .N_DIGITS    (4),
        .REFRESH_DIV (4),
        .DEAD_CYC    (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_exp(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_blank(input string tag);
        chk({tag, " an"},  32'(an),         32'hF);
        chk({tag, " seg"}, 32'(seg),        32'h7F);
        chk({tag, " dp"},  32'(dp),         32'h1);
        chk({tag, " ft"},  32'(frame_tick), 32'h0);
    endtask

    // Starts at the sample right after a commit edge; walks the 20 positions of one frame.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] d, input logic blz,
                               input int la_pos, input logic [15:0] la_v, input logic [3:0] la_d,
                               input int lb_pos, input logic [15:0] lb_v, input logic [3:0] lb_d);
        for (int p = 0; p < 20; p++) begin
            int          dig;
            logic        lit;
            logic [15:0] upper;
            logic [3:0]  nib;
            logic [3:0]  e_an;
            logic [6:0]  e_seg;
            logic        e_dp;
            dig   = p / 5;
            upper = v >> (4 * dig);
            nib   = upper[3:0];
            lit   = (p % 5 != 4) && !(blz && dig > 0 && upper == 16'h0);
            e_an  = lit ? ~(4'b0001 << dig) : 4'hF;
            e_seg = lit ? seg_exp(nib) : 7'h7F;
            e_dp  = lit ? ~d[dig] : 1'b1;
            chk($sformatf("an v=%04h p=%0d", v, p),  32'(an),         32'(e_an));
            chk($sformatf("seg v=%04h p=%0d", v, p), 32'(seg),        32'(e_seg));
            chk($sformatf("dp v=%04h p=%0d", v, p),  32'(dp),         32'(e_dp));
            chk($sformatf("ft v=%04h p=%0d", v, p),  32'(frame_tick), 32'(p == 0));
            load = 1'b0;
            if (p == la_pos) begin
                load = 1'b1; value_in = la_v; dp_in = la_d;
            end
            if (p == lb_pos) begin
                load = 1'b1; value_in = lb_v; dp_in = lb_d;
            end
            cyc();
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; blank_lz = 1'b0;
        value_in = 16'h0; dp_in = 4'h0;
        repeat (3) cyc();
        chk_blank("reset");
        rst = 1'b0;
        cyc();

        // Zero display with blanking off; 1234 loaded mid-frame must not tear.
        check_frame(16'h0000, 4'h0, 1'b0, 7, 16'h1234, 4'h0, -1, 16'h0, 4'h0);
        check_frame(16'h1234, 4'h0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        blank_lz = 1'b1;
        // Two loads in one frame: the last one wins.
        check_frame(16'h1234, 4'h0, 1'b1, 3, 16'h9999, 4'h0, 10, 16'h0050, 4'h0);
        check_frame(16'h0050, 4'h0, 1'b1, 3, 16'h0000, 4'h0, -1, 16'h0, 4'h0);
        // ABCD loaded on the commit edge lands one frame late.
        check_frame(16'h0000, 4'h0, 1'b1, 3, 16'h1234, 4'b0100, 19, 16'hABCD, 4'h0);
        check_frame(16'h1234, 4'b0100, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        check_frame(16'hABCD, 4'h0, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Disable during digit 1, load while disabled.
        repeat (6) cyc();
        chk("en pre an", 32'(an), 32'hD);
        en = 1'b0; load = 1'b1; value_in = 16'h5678; dp_in = 4'b0001;
        cyc();
        load = 1'b0;
        chk_blank("en off");
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk_blank($sformatf("en low %0d", i));
        end
        en = 1'b1;
        cyc();
        check_frame(16'h5678, 4'b0001, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        // Asynchronous reset mid-digit discards a pending load.
        repeat (2) cyc();
        load = 1'b1; value_in = 16'h1111; dp_in = 4'hF;
        cyc();
        load = 1'b0;
        repeat (3) cyc();
        chk("rst pre an", 32'(an), 32'hD);
        #2 rst = 1'b1;
        #1 chk_blank("rst async");
        @(negedge clk);
        cyc();
        chk_blank("rst held");
        rst = 1'b0;
        cyc();
        check_frame(16'h0000, 4'h0, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        check_frame(16'h0000, 4'h0, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing scan controller for an N-digit common-anode seven-segment display.
- All digits share one segment_7s hex decoder instance (bin_in[3:0] -> seg[6:0], active-low segments).
- Holds a shadow and a display register, cycles digit anodes with a dead-time gap, and supports leading-zero blanking and per-digit decimal points.
- Sits between register/user logic and the board display pins.

Parameters:
- N_DIGITS, 4, number of digits (legal range 1..8).
- REFRESH_DIV, 100000, clock cycles each digit is lit (>=2).
- DEAD_CYC, 16, clock cycles all anodes are off between digits (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  scan enable; low blanks the display.
- load  in  1  one-cycle strobe: capture value_in and dp_in into the shadow register.
- value_in  in  4*N_DIGITS  hex nibbles; nibble i drives digit i, digit 0 = LSB.
- dp_in  in  N_DIGITS  decimal point request per digit, active-high.
- blank_lz  in  1  leading-zero blanking enable.
- an  out  N_DIGITS  digit anodes, active-low.
- seg  out  7  segments, active-low; passed through from the decoder.
- dp  out  1  decimal point, active-low.
- frame_tick  out  1  one-cycle pulse on each entry to digit 0.

Behaviour:
- Reset (async, rst=1):
  - state=DEAD, cnt=0, idx=N_DIGITS-1.
  - shadow=0, disp=0, pending=0.
  - an=all 1, seg=7'h7F, dp=1, frame_tick=0.
- Registered outputs: an, seg, dp and frame_tick change on the same edge as the state/idx transition. No combinational path from inputs to outputs.
- FSM states are ON and DEAD. cnt width is clog2(max(REFRESH_DIV, DEAD_CYC)).
  - ON: cnt counts 0..REFRESH_DIV-1. On the edge where cnt==REFRESH_DIV-1: go to DEAD, cnt=0. ON lasts exactly REFRESH_DIV cycles.
  - DEAD: an=all 1, seg=7'h7F, dp=1. On the edge where cnt==DEAD_CYC-1: go to ON, cnt=0, idx = (idx==N_DIGITS-1) ? 0 : idx+1. DEAD lasts exactly DEAD_CYC cycles.
- Frame period = N_DIGITS*(REFRESH_DIV+DEAD_CYC) cycles.
- Commit: on the DEAD->ON edge into idx 0:
  - frame_tick=1 for that one cycle.
  - If pending: disp<=shadow (value and dp bits), pending<=0.
  - The display never changes mid-frame (no tearing).
- load: shadow<=value_in/dp_in and pending<=1 at the next edge. Repeated loads in a frame overwrite; the last one wins.
- load on the commit edge: the commit uses the old shadow, the new value is captured, pending stays 1, and the new value shows next frame.
- ON digit idx:
  - an = ~(1<<idx).
  - seg = decode(disp nibble idx).
  - dp = ~disp_dp[idx].
- Leading-zero blanking: when blank_lz=1 and idx>0 and all disp nibbles idx..N_DIGITS-1 are zero, the digit is blanked: an=all 1, seg=7'h7F, dp=1 (dp ignored). Digit 0 is never blanked. Timing is unchanged.
- en=0 (sampled on the edge): state=DEAD, cnt=0, idx=N_DIGITS-1, outputs blank, frame_tick=0.
  - Held there while en=0. load is still accepted.
  - When en returns to 1: DEAD runs for DEAD_CYC cycles, then enters digit 0 (commit + frame_tick).
- rst mid-scan: outputs blank immediately (asynchronous). After release, scanning behaves as from power-up and the pending load is discarded.
- cnt and idx never take values outside their ranges. Exactly one anode at most is low at any time.

Test Plan (N_DIGITS=4, REFRESH_DIV=4, DEAD_CYC=1; frame = 20 cycles):
- Assert rst mid-digit -> an=4'b1111, seg=7'h7F, dp=1 before the next clk edge. Release with en=1 -> on the 1st edge an=4'b1110, seg=decode(0), frame_tick=1 for 1 cycle.
- load 16'h1234 mid-frame -> old digits are shown until the next digit-0 entry. Then: an=1110/seg=decode(4) for 4 cycles, 1111 for 1 cycle, 1101/decode(3) x4, 1111, 1011/decode(2) x4, 1111, 0111/decode(1) x4. frame_tick period = 20 cycles.
- blank_lz=1:
  - 16'h0050 -> digits 3 and 2 are blank (an=1111 in their windows), digit 1 shows 5, digit 0 shows 0.
  - 16'h0000 -> only digit 0 lit, showing 0.
  - blank_lz=0 with 16'h0000 -> all four digits lit, showing 0.
- load 16'hABCD asserted on the commit edge -> the frame shows the previous value. The next frame shows D,C,B,A.
- dp_in=4'b0100 with load -> dp=0 only during the digit-2 ON window (an=1011), otherwise dp=1.
- en=0 during digit 1 -> next edge blank, no frame_tick while low, load accepted. en=1 -> after 1 DEAD cycle an=1110, frame_tick=1, and the loaded value is shown.
